// File: rtl/branch_resolve_if.sv
// ID-stage branch request bus: decoded branch, operand sources, forward selects
// and the EX/MEM destination info needed for load-use detection.
interface branch_resolve_if;
   logic        id_valid;
   logic [2:0]  id_br_op;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [15:0] id_imm16;
   logic [31:0] id_pc4;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] ex_result;
   logic [31:0] mem_result;
   logic [31:0] wr_result;
   logic [1:0]  branchforwardA;
   logic [1:0]  branchforwardB;
   logic [4:0]  ex_rw;
   logic        ex_regWr;
   logic        ex_memtoreg;
   logic [4:0]  mem_rw;
   logic        mem_regWr;
   logic        mem_memtoreg;

   modport master (
      output id_valid, id_br_op, id_rs, id_rt, id_imm16, id_pc4,
             rs_data, rt_data, ex_result, mem_result, wr_result,
             branchforwardA, branchforwardB,
             ex_rw, ex_regWr, ex_memtoreg, mem_rw, mem_regWr, mem_memtoreg
   );

   modport slave (
      input  id_valid, id_br_op, id_rs, id_rt, id_imm16, id_pc4,
             rs_data, rt_data, ex_result, mem_result, wr_result,
             branchforwardA, branchforwardB,
             ex_rw, ex_regWr, ex_memtoreg, mem_rw, mem_regWr, mem_memtoreg
   );
endinterface

// File: rtl/branch_resolve.sv
// ID-stage branch resolution: operand muxing, condition/target evaluation,
// load-use stall sequencing and registered PC redirect / IF-ID flush.
module branch_resolve #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   branch_resolve_if.slave  id,
   output logic             br_stall,
   output logic             pc_src,
   output logic [31:0]      br_target,
   output logic             if_flush,
   output logic [CNT_W-1:0] br_total,
   output logic [CNT_W-1:0] br_taken
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STALL2 = 2'd1,
      STALL1 = 2'd2
   } state_t;

   state_t      state;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [31:0] target;
   logic        is_br;
   logic        uses_rt;
   logic        hz_ex;
   logic        hz_mem;
   logic        hazard;
   logic        cond;
   logic        resolve;

   always_comb begin
      op_a = id.rs_data;
      unique case (id.branchforwardA)
         2'b00: op_a = id.rs_data;
         2'b01: op_a = id.ex_result;
         2'b10: op_a = id.mem_result;
         2'b11: op_a = id.wr_result;
         default: op_a = id.rs_data;
      endcase
   end

   always_comb begin
      op_b = id.rt_data;
      unique case (id.branchforwardB)
         2'b00: op_b = id.rt_data;
         2'b01: op_b = id.ex_result;
         2'b10: op_b = id.mem_result;
         2'b11: op_b = id.wr_result;
         default: op_b = id.rt_data;
      endcase
   end

   assign is_br   = id.id_valid & (id.id_br_op != 3'b000) & (id.id_br_op != 3'b111);
   assign uses_rt = (id.id_br_op == 3'b001) | (id.id_br_op == 3'b010);

   // r0 never carries a real load result, so it cannot create a hazard
   assign hz_ex  = id.ex_regWr & id.ex_memtoreg & (id.ex_rw != 5'd0) &
                   ((id.ex_rw == id.id_rs) | (uses_rt & (id.ex_rw == id.id_rt)));
   assign hz_mem = id.mem_regWr & id.mem_memtoreg & (id.mem_rw != 5'd0) &
                   ((id.mem_rw == id.id_rs) | (uses_rt & (id.mem_rw == id.id_rt)));
   assign hazard = hz_ex | hz_mem;

   always_comb begin
      cond = 1'b0;
      unique case (id.id_br_op)
         3'b001: cond = (op_a == op_b);
         3'b010: cond = (op_a != op_b);
         3'b011: cond = ~op_a[31] & (op_a != '0);
         3'b100: cond = op_a[31] | (op_a == '0);
         3'b101: cond = op_a[31];
         3'b110: cond = ~op_a[31];
         default: cond = 1'b0;
      endcase
   end

   assign target  = id.id_pc4 + {{14{id.id_imm16[15]}}, id.id_imm16, 2'b00};
   assign resolve = (state == IDLE) & is_br & ~hazard;

   assign br_stall = rst_n & ((state != IDLE) | (is_br & hazard));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc_src    <= 1'b0;
         if_flush  <= 1'b0;
         br_target <= '0;
         br_total  <= '0;
         br_taken  <= '0;
      end else begin
         pc_src   <= 1'b0;
         if_flush <= 1'b0;
         unique case (state)
            IDLE: begin
               if (is_br && hz_ex)
                  state <= STALL2;
               else if (is_br && hz_mem)
                  state <= STALL1;
               else
                  state <= IDLE;
            end
            STALL2: state <= id.id_valid ? STALL1 : IDLE;
            STALL1: state <= IDLE;
            default: state <= IDLE;
         endcase

         if (resolve) begin
            if (br_total != '1)
               br_total <= br_total + 1'b1;
            if (cond) begin
               pc_src    <= 1'b1;
               if_flush  <= 1'b1;
               br_target <= target;
               if (br_taken != '1)
                  br_taken <= br_taken + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve.sv
// Randomized + directed bench for branch_resolve against a countdown-based
// reference model; a CNT_W=4 copy shares the bus to exercise saturation.
module tb_branch_resolve;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        br_stall, pc_src, if_flush;
   logic [31:0] br_target, br_total, br_taken;
   logic        br_stall4, pc_src4, if_flush4;
   logic [31:0] br_target4;
   logic [3:0]  br_total4, br_taken4;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // reference model state
   int          stall_left = 0;
   logic        e_stall;
   logic        e_pc = 1'b0;
   logic [31:0] e_tgt = '0;
   logic [31:0] e_tot = '0, e_tk = '0;
   int          e_tot4 = 0, e_tk4 = 0;

   branch_resolve_if bif ();

   always #5 clk = ~clk;

   branch_resolve #(.CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .id(bif),
      .br_stall(br_stall), .pc_src(pc_src), .br_target(br_target),
      .if_flush(if_flush), .br_total(br_total), .br_taken(br_taken)
   );

   branch_resolve #(.CNT_W(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .id(bif),
      .br_stall(br_stall4), .pc_src(pc_src4), .br_target(br_target4),
      .if_flush(if_flush4), .br_total(br_total4), .br_taken(br_taken4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      bif.id_valid = 1'b0;       bif.id_br_op = 3'b000;
      bif.id_rs = 5'd0;          bif.id_rt = 5'd0;
      bif.id_imm16 = 16'h0;      bif.id_pc4 = 32'h0;
      bif.rs_data = 32'h0;       bif.rt_data = 32'h0;
      bif.ex_result = 32'h0;     bif.mem_result = 32'h0;
      bif.wr_result = 32'h0;
      bif.branchforwardA = 2'b00; bif.branchforwardB = 2'b00;
      bif.ex_rw = 5'd0;  bif.ex_regWr = 1'b0;  bif.ex_memtoreg = 1'b0;
      bif.mem_rw = 5'd0; bif.mem_regWr = 1'b0; bif.mem_memtoreg = 1'b0;
   endtask

   function automatic logic load_hit(input logic wr, input logic ld, input logic [4:0] rw,
                                     input logic two_ops);
      if (!(wr && ld) || rw == 5'd0) return 1'b0;
      return (rw == bif.id_rs) || (two_ops && rw == bif.id_rt);
   endfunction

   function automatic logic taken(input logic [31:0] a, input logic [31:0] b);
      int sa;
      sa = int'(a);
      case (bif.id_br_op)
         3'd1: return a == b;
         3'd2: return a != b;
         3'd3: return sa > 0;
         3'd4: return sa <= 0;
         3'd5: return sa < 0;
         3'd6: return sa >= 0;
         default: return 1'b0;
      endcase
   endfunction

   // One clock cycle with the currently driven inputs.
   task automatic step();
      logic [31:0] src [4];
      logic        branch, two_ops, hze, hzm;
      logic signed [15:0] simm;
      int          off;
      src[0] = bif.rs_data;  src[1] = bif.ex_result;
      src[2] = bif.mem_result; src[3] = bif.wr_result;
      branch  = bif.id_valid && bif.id_br_op inside {[3'd1:3'd6]};
      two_ops = bif.id_br_op inside {3'd1, 3'd2};
      hze = load_hit(bif.ex_regWr, bif.ex_memtoreg, bif.ex_rw, two_ops);
      hzm = load_hit(bif.mem_regWr, bif.mem_memtoreg, bif.mem_rw, two_ops);

      e_pc = 1'b0;
      if (!rst_n) begin
         e_stall = 1'b0; stall_left = 0; e_tgt = '0;
         e_tot = '0; e_tk = '0; e_tot4 = 0; e_tk4 = 0;
      end else if (stall_left > 0) begin
         e_stall = 1'b1;
         stall_left = bif.id_valid ? stall_left - 1 : 0;
      end else if (branch && (hze || hzm)) begin
         e_stall = 1'b1;
         stall_left = hze ? 2 : 1;
      end else begin
         e_stall = 1'b0;
         if (branch) begin
            if (e_tot != 32'hFFFF_FFFF) e_tot++;
            if (e_tot4 < 15) e_tot4++;
            src[0] = bif.rs_data;
            if (taken(src[bif.branchforwardA],
                      bif.branchforwardB == 2'b00 ? bif.rt_data : src[bif.branchforwardB])) begin
               e_pc = 1'b1;
               simm = bif.id_imm16;
               off  = simm;
               e_tgt = bif.id_pc4 + 32'(off * 4);
               if (e_tk != 32'hFFFF_FFFF) e_tk++;
               if (e_tk4 < 15) e_tk4++;
            end
         end
      end

      @(negedge clk);
      check("br_stall", {31'd0, br_stall}, {31'd0, e_stall});
      @(posedge clk);
      #1;
      check("pc_src",    {31'd0, pc_src},   {31'd0, e_pc});
      check("if_flush",  {31'd0, if_flush}, {31'd0, e_pc});
      check("br_target", br_target, e_tgt);
      check("br_total",  br_total,  e_tot);
      check("br_taken",  br_taken,  e_tk);
      check("br_total4", {28'd0, br_total4}, 32'(e_tot4));
      check("br_taken4", {28'd0, br_taken4}, 32'(e_tk4));
   endtask

   function automatic logic [31:0] rnd_data();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'($urandom_range(0, 3));
         3: return 32'hFFFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      // reset holds outputs low even with a hazarded branch present
      bif.id_valid = 1'b1; bif.id_br_op = 3'd1; bif.id_rs = 5'd3;
      bif.ex_rw = 5'd3; bif.ex_regWr = 1'b1; bif.ex_memtoreg = 1'b1;
      step(); step();
      rst_n = 1'b1;

      // beq taken with negative offset: 0x100 + (-1<<2) = 0xFC
      clear_inputs();
      bif.id_valid = 1'b1; bif.id_br_op = 3'd1; bif.id_rs = 5'd1; bif.id_rt = 5'd2;
      bif.rs_data = 32'd5; bif.rt_data = 32'd5; bif.id_imm16 = 16'hFFFF; bif.id_pc4 = 32'h100;
      step();
      check("tgt_fc", br_target, 32'h0000_00FC);

      // bne with forwarded equal operands: not taken
      bif.id_br_op = 3'd2; bif.branchforwardA = 2'b01; bif.branchforwardB = 2'b10;
      bif.ex_result = 32'd7; bif.mem_result = 32'd7;
      step();

      // EX load hazard on rs: three stall cycles then resolve
      clear_inputs();
      bif.id_valid = 1'b1; bif.id_br_op = 3'd1; bif.id_rs = 5'd3; bif.id_rt = 5'd4;
      bif.id_pc4 = 32'h2000; bif.id_imm16 = 16'h0010;
      bif.ex_rw = 5'd3; bif.ex_regWr = 1'b1; bif.ex_memtoreg = 1'b1;
      step(); step(); step();
      bif.ex_regWr = 1'b0; bif.branchforwardA = 2'b11; bif.wr_result = 32'd9; bif.rt_data = 32'd9;
      step();

      // MEM load hazard only: two stall cycles
      bif.mem_rw = 5'd4; bif.mem_regWr = 1'b1; bif.mem_memtoreg = 1'b1;
      step(); step();
      bif.mem_regWr = 1'b0;
      step();

      // bgtz ignores rt hazards; 0x80000000 not > 0 but is <= 0
      clear_inputs();
      bif.id_valid = 1'b1; bif.id_br_op = 3'd3; bif.id_rs = 5'd1; bif.id_rt = 5'd6;
      bif.ex_rw = 5'd6; bif.ex_regWr = 1'b1; bif.ex_memtoreg = 1'b1;
      bif.rs_data = 32'h8000_0000; bif.id_pc4 = 32'h40; bif.id_imm16 = 16'h0004;
      step();
      bif.id_br_op = 3'd4;
      step();

      // abort in STALL2
      clear_inputs();
      bif.id_valid = 1'b1; bif.id_br_op = 3'd1; bif.id_rs = 5'd5;
      bif.ex_rw = 5'd5; bif.ex_regWr = 1'b1; bif.ex_memtoreg = 1'b1;
      step();
      bif.id_valid = 1'b0;
      step(); step();

      // reset in STALL1
      bif.id_valid = 1'b1; bif.ex_regWr = 1'b0;
      bif.mem_rw = 5'd5; bif.mem_regWr = 1'b1; bif.mem_memtoreg = 1'b1;
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;

      // enough taken branches to saturate the 4-bit counters
      clear_inputs();
      bif.id_valid = 1'b1; bif.id_br_op = 3'd6; bif.id_pc4 = 32'hFFFF_FFF0; bif.id_imm16 = 16'h0008;
      for (int i = 0; i < 18; i++) step();
      check("sat4", {28'd0, br_total4}, 32'hF);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         bif.id_valid = ($urandom_range(0, 9) < 8);
         bif.id_br_op = 3'($urandom_range(0, 7));
         bif.id_rs = 5'($urandom_range(0, 5));
         bif.id_rt = 5'($urandom_range(0, 5));
         bif.id_imm16 = 16'($urandom);
         bif.id_pc4 = $urandom;
         bif.rs_data = rnd_data();
         bif.rt_data = ($urandom_range(0, 2) == 0) ? bif.rs_data : rnd_data();
         bif.ex_result = rnd_data(); bif.mem_result = rnd_data(); bif.wr_result = rnd_data();
         bif.branchforwardA = 2'($urandom_range(0, 3));
         bif.branchforwardB = 2'($urandom_range(0, 3));
         bif.ex_rw = 5'($urandom_range(0, 5));
         bif.ex_regWr = 1'($urandom_range(0, 1)); bif.ex_memtoreg = ($urandom_range(0, 2) == 0);
         bif.mem_rw = 5'($urandom_range(0, 5));
         bif.mem_regWr = 1'($urandom_range(0, 1)); bif.mem_memtoreg = ($urandom_range(0, 2) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
ID-stage branch resolution unit. It sits directly downstream of the branch forwarding selector. It consumes the 2-bit forward selects for rs and rt, muxes the comparison operands, evaluates the branch condition and computes the target. It also sequences load-use stalls for branch operands and drives a registered PC redirect and IF/ID flush.

Parameters:
CNT_W, 32, width of the saturating branch statistics counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID-stage instruction valid
id_br_op  in  3  000 none, 001 beq, 010 bne, 011 bgtz, 100 blez, 101 bltz, 110 bgez, 111 none
id_rs  in  5  rs register number
id_rt  in  5  rt register number
id_imm16  in  16  branch offset, in words
id_pc4  in  32  PC+4 of the branch
rs_data  in  32  register file read, rs
rt_data  in  32  register file read, rt
ex_result  in  32  EX-stage ALU result
mem_result  in  32  MEM-stage ALU result
wr_result  in  32  WB-stage write data
branchforwardA  in  2  rs operand select: 00 regfile, 01 EX, 10 MEM, 11 WB
branchforwardB  in  2  rt operand select, same encoding
ex_rw  in  5  EX-stage destination register
ex_regWr  in  1  EX-stage write enable
ex_memtoreg  in  1  EX-stage instruction is a load
mem_rw  in  5  MEM-stage destination register
mem_regWr  in  1  MEM-stage write enable
mem_memtoreg  in  1  MEM-stage instruction is a load
br_stall  out  1  hold PC and IF/ID, insert bubble into EX
pc_src  out  1  registered one-cycle redirect pulse
br_target  out  32  registered redirect address
if_flush  out  1  registered one-cycle IF/ID flush pulse
br_total  out  CNT_W  resolved branches, saturating
br_taken  out  CNT_W  taken branches, saturating

Behaviour:
- Reset: rst_n=0 sampled at a clock edge forces state=IDLE, pc_src=0, if_flush=0, br_target=0, br_total=0, br_taken=0. br_stall=0 while in reset.
- Operand A is selected from {rs_data, ex_result, mem_result, wr_result} by branchforwardA. Operand B is selected the same way by branchforwardB.
- Conditions use signed 32-bit compares against zero:
  - beq: A==B. bne: A!=B.
  - bgtz: A>0. blez: A<=0. bltz: A<0. bgez: A>=0.
- Only beq and bne use rt.
- Target = id_pc4 + (sign-extended id_imm16 << 2), truncated to 32 bits. Wrap-around is permitted.
- is_br = id_valid and id_br_op in 001..110.
- uses_rt = op is beq or bne.
- Load-use hazard terms, each requiring the destination register to be non-zero:
  - hz_ex = ex_regWr & ex_memtoreg & ex_rw!=0 & (ex_rw==id_rs | (uses_rt & ex_rw==id_rt)).
  - hz_mem = the same test using the mem_* signals.
- FSM states: IDLE, STALL2, STALL1.
  - IDLE, is_br & hz_ex: go to STALL2, br_stall=1.
  - IDLE, is_br & hz_mem & !hz_ex: go to STALL1, br_stall=1.
  - IDLE, is_br with no hazard: resolve this cycle, br_stall=0, stay in IDLE.
  - STALL2: br_stall=1, go to STALL1.
  - STALL1: br_stall=1, go to IDLE. The branch resolves in IDLE on the following cycle with forwarded data.
- br_stall is combinational: (state!=IDLE) | (state==IDLE & is_br & (hz_ex|hz_mem)).
- Abort: if id_valid=0 in STALL2 or STALL1, the FSM returns to IDLE next cycle. No resolve and no counter update.
- Resolve at clock edge (IDLE, is_br, no hazard):
  - br_total increments.
  - If the condition is true: pc_src<=1, if_flush<=1, br_target<=target, br_taken increments.
  - Otherwise pc_src and if_flush are cleared to 0.
- pc_src and if_flush are 0 on every non-resolve cycle. They are high for exactly one cycle per taken branch.
- br_target holds its last value when no taken branch resolves.
- Counters saturate at all ones and never wrap.
- A reset asserted mid-stall overrides everything. The pending branch is discarded.
- id_br_op 000 or 111 is never a branch. It causes no stall and no count.

Test Plan:
- beq, rs_data=rt_data=5, selects 00, no hazards -> next cycle pc_src=1, if_flush=1, br_target=id_pc4+(imm<<2). With imm=0xFFFF and pc4=0x100, br_target=0xFC. br_total=1, br_taken=1.
- bne, selects A=01 (ex_result=7), B=10 (mem_result=7) -> not taken, pc_src=0, br_total increments, br_taken unchanged.
- beq with ex_memtoreg=1, ex_regWr=1, ex_rw=id_rs=3 -> br_stall high for 3 consecutive cycles (IDLE, STALL2, STALL1), then resolves in the 4th cycle. With mem_memtoreg hazard only -> 2 stall cycles.
- bgtz with a load hazard on rt only (ex_rw=id_rt) -> no stall. bgtz with A=0x80000000 -> not taken. blez with the same A -> taken.
- Drop id_valid during STALL2 -> IDLE next cycle, no pc_src, counters unchanged. Assert rst_n=0 during STALL1 -> all outputs 0 after the edge.
- Force br_total to all ones (CNT_W=4 build, 16 branches) -> the count stays at 0xF.
